// File: rtl/eth_mac_tx_framer.sv
// Ethernet MAC transmit framer: AXI-Stream bytes in, GMII bytes out with preamble, SFD, FCS and IFG.
// Build option TX_PAD_EN: zero-pad frames shorter than MIN_FRAME_BYTES before the FCS.
//
// state    | meaning
// IDLE     | waiting for tvalid; CRC and byte count re-armed
// PREAMBLE | 0x55 on the wire, 7 cycles
// SFD      | 0xD5 on the wire, first payload byte accepted
// DATA     | payload bytes accepted and forwarded
// PAD      | zero fill up to MIN_FRAME_BYTES
// FCS      | ~crc sent LSB first, 4 bytes
// DROP     | underrun recovery, swallow input up to tlast
// IFG      | inter-frame gap, tx_en low
module eth_mac_tx_framer #(
    parameter int IFG_BYTES       = 12,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] s_tx_axis_tdata,
    input  logic       s_tx_axis_tvalid,
    input  logic       s_tx_axis_tlast,
    input  logic       s_tx_axis_tuser,
    output logic       s_tx_axis_tready,
    output logic [7:0] o_gmii_txd,
    output logic       o_gmii_tx_en,
    output logic       o_gmii_tx_er,
    output logic       o_busy,
    output logic       o_frame_done
);

`ifdef TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    localparam logic [7:0]  IFG_LOAD = 8'(IFG_BYTES);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_DROP, S_IFG
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        tready_q, tready_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic [15:0] byte_inc;
    logic [31:0] fcs;
    logic        accept;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign byte_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
    assign fcs      = ~crc_q;
    assign accept   = s_tx_axis_tvalid & tready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        crc_d        = crc_q;
        byte_cnt_d   = byte_cnt_q;
        txd_d        = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        tready_d     = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                crc_d      = 32'hFFFFFFFF;
                byte_cnt_d = 16'd0;
                if (s_tx_axis_tvalid) begin
                    state_d = S_PREAMBLE;
                    cnt_d   = 8'd6;
                    txd_d   = 8'h55;
                    tx_en_d = 1'b1;
                end
            end
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d  = S_SFD;
                    txd_d    = 8'hD5;
                    tready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    txd_d = 8'h55;
                end
            end
            S_SFD, S_DATA: begin
                tx_en_d = 1'b1;
                if (accept) begin
                    txd_d      = s_tx_axis_tdata;
                    crc_d      = crc_next(crc_q, s_tx_axis_tdata);
                    byte_cnt_d = byte_inc;
                    if (s_tx_axis_tlast) begin
                        if (s_tx_axis_tuser) begin
                            tx_er_d      = 1'b1;
                            frame_done_d = 1'b1;
                            state_d      = S_IFG;
                            cnt_d        = IFG_LOAD;
                        end else if (PAD_ON && (byte_inc < MIN_LEN)) begin
                            state_d = S_PAD;
                        end else begin
                            state_d = S_FCS;
                            cnt_d   = 8'd3;
                        end
                    end else begin
                        state_d  = S_DATA;
                        tready_d = 1'b1;
                    end
                end else begin
                    // Underrun: poison the frame on the wire, then recover in DROP.
                    tx_er_d  = 1'b1;
                    state_d  = S_DROP;
                    tready_d = 1'b1;
                end
            end
            S_PAD: begin
                tx_en_d    = 1'b1;
                crc_d      = crc_next(crc_q, 8'h00);
                byte_cnt_d = byte_inc;
                if (byte_inc >= MIN_LEN) begin
                    state_d = S_FCS;
                    cnt_d   = 8'd3;
                end
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                case (cnt_q[1:0])
                    2'd3:    txd_d = fcs[7:0];
                    2'd2:    txd_d = fcs[15:8];
                    2'd1:    txd_d = fcs[23:16];
                    default: txd_d = fcs[31:24];
                endcase
                if (cnt_q == 8'd0) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IFG;
                    cnt_d        = IFG_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DROP: begin
                if (accept && s_tx_axis_tlast) begin
                    state_d = S_IFG;
                    cnt_d   = IFG_LOAD;
                end else begin
                    tready_d = 1'b1;
                end
            end
            S_IFG: begin
                // First IFG cycle still shows the final byte, so the wire sees IFG_BYTES idle cycles here.
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            crc_q        <= 32'hFFFFFFFF;
            byte_cnt_q   <= 16'd0;
            txd_q        <= 8'h00;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            tready_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            byte_cnt_q   <= byte_cnt_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            tready_q     <= tready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s_tx_axis_tready = tready_q;
    assign o_gmii_txd       = txd_q;
    assign o_gmii_tx_en     = tx_en_q;
    assign o_gmii_tx_er     = tx_er_q;
    assign o_busy           = busy_q;
    assign o_frame_done     = frame_done_q;

endmodule

// File: doc/eth_mac_tx_framer.md
Name: eth_mac_tx_framer

Overview:
- Transmit-side MAC framer for the Ethernet MAC project top.
- Converts an 8-bit AXI-Stream frame from the feedback/loopback path into a GMII byte stream for the RGMII TX output stage.
- Adds preamble and SFD, optionally pads to the minimum frame length, appends CRC-32 FCS, and enforces the inter-frame gap.
- It is the counterpart to the RX-side deframer: it produces what the bench samples on rgmii_phy_txd/txctl.

Parameters:
IFG_BYTES, 12, idle cycles (tx_en low) enforced after every frame, including aborted ones; range 1..255
MIN_FRAME_BYTES, 60, minimum data+pad length before FCS; used only when TX_PAD_EN is defined

Ports:
i_clk  in  1  single clock; GMII byte clock (125 MHz)
i_reset_n  in  1  asynchronous, active-low reset
s_tx_axis_tdata  in  8  frame byte; destination MAC first
s_tx_axis_tvalid  in  1  byte valid
s_tx_axis_tlast  in  1  last byte of frame
s_tx_axis_tuser  in  1  abort; sampled with tlast
s_tx_axis_tready  out  1  byte accepted when tvalid & tready
o_gmii_txd  out  8  GMII transmit data
o_gmii_tx_en  out  1  GMII transmit enable
o_gmii_tx_er  out  1  GMII transmit error
o_busy  out  1  high in any state other than IDLE
o_frame_done  out  1  one-cycle pulse on the last FCS byte, or on the error byte of an aborted frame

Behaviour:
- Reset (asynchronous, any state): all outputs 0, FSM to IDLE, CRC to 0xFFFFFFFF, counters cleared.
- All GMII outputs are registered. A value decided in a cycle appears on o_gmii_* at the next rising edge.
- FSM states: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DROP, IFG.
- IDLE: tready=0. If tvalid=1, go to PREAMBLE; the first 0x55 is driven the following cycle.
- PREAMBLE: drive 0x55 for 7 cycles, then SFD.
- SFD: drive 0xD5 for 1 cycle. tready=1 in this cycle, so the first data byte is accepted and appears on txd immediately after 0xD5.
- DATA:
  - tready=1.
  - Each accepted byte is driven on txd the next cycle and folded into the CRC.
  - A 16-bit byte counter increments per byte and saturates at 0xFFFF.
- tlast with tuser=0:
  - TX_PAD_EN defined and count < MIN_FRAME_BYTES: go to PAD.
  - Otherwise: go to FCS.
- tlast with tuser=1: drive that byte with tx_er=1, pulse frame_done, skip FCS, go to IFG.
- Underrun (tvalid=0 in DATA, before tlast):
  - Drive tx_en=1, tx_er=1, txd=0x00 for one cycle.
  - Go to DROP.
- DROP:
  - tx_en=0, tready=1.
  - Discard input until tlast is accepted, then go to IFG. No frame_done pulse.
- PAD: drive 0x00 (CRC updated) until count reaches MIN_FRAME_BYTES, then FCS.
- FCS:
  - CRC is reflected CRC-32 (poly 0xEDB88320), init 0xFFFFFFFF, over data+pad only (not preamble/SFD).
  - Transmit ~crc as 4 bytes, LSB first.
  - frame_done pulses with the 4th byte; then go to IFG.
- IFG:
  - tx_en=0, txd=0x00, tready=0.
  - Count IFG_BYTES cycles, then go to IDLE.
  - A pending tvalid is accepted in IDLE on the next cycle. Back-to-back gap between frames is IFG_BYTES+1 cycles of tx_en low.
- tx_en is continuous from the first preamble byte to the last FCS byte of a good frame.
- tready is never asserted in PREAMBLE, PAD, FCS or IFG.

Optional Feature:
- Macro: TX_PAD_EN.
- Defined: frames shorter than MIN_FRAME_BYTES are zero-padded before the FCS, and padding is included in the CRC.
- Undefined: no padding; the FCS immediately follows the last data byte for any length ≥1; PAD state unreachable.

Test Plan:
1. Reset during DATA of a 40-byte frame -> on the same cycle as reset assertion, txd=0, tx_en=0, tx_er=0, tready=0. After release, the next frame transmits normally with correct FCS.
2. TX_PAD_EN undefined, send ASCII "123456789" (9 bytes):
   - txd sequence: 7×0x55, 0xD5, 0x31..0x39, then 0x26 0x39 0xF4 0xCB.
   - tx_en high for exactly 21 cycles; frame_done on the 0xCB cycle.
3. TX_PAD_EN defined, same 9 bytes -> 51 bytes of 0x00 follow the data, then a 4-byte FCS matching a reference CRC over 60 bytes. tx_en high for exactly 72 cycles.
4. Two 64-byte frames with tvalid held high -> tx_en low for exactly 13 cycles between frames (IFG_BYTES=12); both FCS values correct.
5. Underrun: tvalid drops after byte 20 of 50 ->
   - one cycle with tx_en=1, tx_er=1; then tx_en=0.
   - Remaining 30 bytes are accepted and discarded; no FCS; no frame_done.
   - The following frame is correct.
6. Abort: 30-byte frame with tuser=1 on tlast -> byte 30 driven with tx_er=1, frame_done pulses, no FCS bytes, then 12 IFG cycles.
